// File: rtl/pwm_cfg_scheduler.sv
// pwm_cfg_scheduler: shadow/active config register bank for the PWM output stage.
// Writes land in shadow registers; all shadows are copied to the active registers in a
// single cycle at a PWM period boundary, so outputs never see a partial configuration.
// Writes to unmapped addresses are accepted, dropped and flagged on o_addr_err.
// Optional macro PWM_CFG_TIMEOUT_EN: forces a commit after TIMEOUT_CYCLES in PENDING.
module pwm_cfg_scheduler #(
  parameter int unsigned NUM_REGS       = 5,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TO_W           = 10
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr_valid,
  output logic       o_wr_ready,
  input  logic [6:0] i_wr_addr,
  input  logic [7:0] i_wr_data,
  input  logic       i_period_start,
  output logic [7:0] o_en_out,
  output logic [7:0] o_en_uio,
  output logic [7:0] o_pwm_out,
  output logic [7:0] o_pwm_uio,
  output logic [7:0] o_duty,
  output logic       o_pending,
  output logic       o_commit,
  output logic       o_addr_err
);

  typedef enum logic [1:0] {StIdle, StPending, StCommit} state_e;

  state_e     r_state;
  state_e     w_state_nxt;
  logic       r_rdy;
  logic       r_addr_err;
  logic [7:0] r_shadow [NUM_REGS];
  logic [7:0] r_active [NUM_REGS];

  logic       w_ready;
  logic       w_commit;
  logic       w_pending;
  logic       w_wr_fire;
  logic       w_wr_mapped;
  logic       w_timeout;

  assign w_wr_fire   = i_wr_valid & w_ready;
  assign w_wr_mapped = (32'(i_wr_addr) < NUM_REGS);

`ifdef PWM_CFG_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;

  // Timeout counter: held at zero outside PENDING, so it restarts on every entry
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_to_cnt <= '0;
    end else if (r_state != StPending) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == StPending) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register plus ready flag that rises on the first edge after reset release
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rdy   <= 1'b1;
    end
  end

  // Next-state and handshake/status outputs
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_commit    = 1'b0;
    w_pending   = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_ready = r_rdy;
        if (w_wr_fire && w_wr_mapped) w_state_nxt = StPending;
      end
      StPending: begin
        w_ready   = r_rdy;
        w_pending = 1'b1;
        if (i_period_start || w_timeout) w_state_nxt = StCommit;
      end
      StCommit: begin
        w_commit    = 1'b1;
        w_pending   = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Shadow bank: a mapped accepted write updates one register; last write wins
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_shadow[i] <= 8'h00;
    end else if (w_wr_fire && w_wr_mapped) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (32'(i_wr_addr) == i) r_shadow[i] <= i_wr_data;
      end
    end
  end

  // Active bank: loads every shadow at the edge that closes the COMMIT cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_active[i] <= 8'h00;
    end else if (r_state == StCommit) begin
      for (int i = 0; i < NUM_REGS; i++) r_active[i] <= r_shadow[i];
    end
  end

  // Unmapped-address flag, a one-cycle pulse after the dropped write
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= w_wr_fire && !w_wr_mapped;
    end
  end

  assign o_wr_ready = w_ready;
  assign o_commit   = w_commit;
  assign o_pending  = w_pending;
  assign o_addr_err = r_addr_err;
  assign o_en_out   = r_active[0];
  assign o_en_uio   = r_active[1];
  assign o_pwm_out  = r_active[2];
  assign o_pwm_uio  = r_active[3];
  assign o_duty     = r_active[4];

endmodule

// File: tb/tb_pwm_cfg_scheduler.sv
// Directed self-checking bench for pwm_cfg_scheduler.
// Inputs change 1 ns after a rising edge; outputs are checked at that point too.
module tb_pwm_cfg_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [6:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       period_start = 1'b0;
  logic [7:0] en_out, en_uio, pwm_out, pwm_uio, duty;
  logic       pending, commit, addr_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwm_cfg_scheduler #(
    .NUM_REGS      (5),
    .TIMEOUT_CYCLES(16),
    .TO_W          (5)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_wr_valid    (wr_valid),
    .o_wr_ready    (wr_ready),
    .i_wr_addr     (wr_addr),
    .i_wr_data     (wr_data),
    .i_period_start(period_start),
    .o_en_out      (en_out),
    .o_en_uio      (en_uio),
    .o_pwm_out     (pwm_out),
    .o_pwm_uio     (pwm_uio),
    .o_duty        (duty),
    .o_pending     (pending),
    .o_commit      (commit),
    .o_addr_err    (addr_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted write over one edge; optional period_start in the same cycle
  task automatic do_write(input logic [6:0] a, input logic [7:0] d, input logic ps);
    wr_valid     = 1'b1;
    wr_addr      = a;
    wr_data      = d;
    period_start = ps;
    tick();
    wr_valid     = 1'b0;
    period_start = 1'b0;
  endtask

  task automatic pulse_period();
    period_start = 1'b1;
    tick();
    period_start = 1'b0;
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    // Power-on reset state
    #2;
    n_vec++;
    if ({en_out, en_uio, pwm_out, pwm_uio, duty} !== 40'h0 || pending !== 1'b0 ||
        commit !== 1'b0 || addr_err !== 1'b0 || wr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL por_state: got regs=%h p=%b c=%b e=%b r=%b, want all zero",
               {en_out, en_uio, pwm_out, pwm_uio, duty}, pending, commit, addr_err, wr_ready);
    end
    #4 rst_n = 1'b1;
    tick();
    n_vec++;
    if (wr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_por: got %b want 1", wr_ready);
    end
    // Mid-run reset with duty=0x80 active
    do_write(7'h04, 8'h80, 1'b0);
    pulse_period();
    tick();
    n_vec++;
    if (duty !== 8'h80) begin
      n_err++;
      $display("FAIL duty_before_reset: got %h want 80", duty);
    end
    do_write(7'h00, 8'h11, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({en_out, en_uio, pwm_out, pwm_uio, duty} !== 40'h0 || pending !== 1'b0 ||
        commit !== 1'b0 || wr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_reset: got regs=%h p=%b c=%b r=%b, want all zero",
               {en_out, en_uio, pwm_out, pwm_uio, duty}, pending, commit, wr_ready);
    end
    #2 rst_n = 1'b1;
    tick();
    n_vec++;
    if (wr_ready !== 1'b1 || pending !== 1'b0) begin
      n_err++;
      $display("FAIL ready_after_reset: got r=%b p=%b want r=1 p=0", wr_ready, pending);
    end
    // The discarded shadow write to reg 0 must not surface on the next commit
    do_write(7'h04, 8'h01, 1'b0);
    pulse_period();
    tick();
    n_vec++;
    if (en_out !== 8'h00 || duty !== 8'h01) begin
      n_err++;
      $display("FAIL shadow_cleared: got en_out=%h duty=%h want 00/01", en_out, duty);
    end
    apply_reset();
  endtask

  task automatic test_basic_commit();
    int hold_bad = 0;
`ifdef PWM_CFG_TIMEOUT_EN
    int wait_cyc = 10;
`else
    int wait_cyc = 20;
`endif
    do_write(7'h04, 8'h40, 1'b0);
    for (int i = 0; i < wait_cyc; i++) begin
      if (duty !== 8'h00 || pending !== 1'b1 || commit !== 1'b0) hold_bad++;
      tick();
    end
    n_vec++;
    if (hold_bad != 0) begin
      n_err++;
      $display("FAIL basic_hold: got %0d bad cycles want 0 (duty=%h p=%b)",
               hold_bad, duty, pending);
    end
    pulse_period();
    n_vec++;
    if (commit !== 1'b1 || duty !== 8'h00 || wr_ready !== 1'b0 || pending !== 1'b1) begin
      n_err++;
      $display("FAIL basic_commit_cycle: got c=%b duty=%h r=%b p=%b want 1/00/0/1",
               commit, duty, wr_ready, pending);
    end
    tick();
    n_vec++;
    if (commit !== 1'b0 || duty !== 8'h40 || pending !== 1'b0 || wr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL basic_after: got c=%b duty=%h p=%b r=%b want 0/40/0/1",
               commit, duty, pending, wr_ready);
    end
  endtask

  task automatic test_merge();
    int ready_low = 0;
    int pulses = 0;
    if (wr_ready !== 1'b1) ready_low++;
    do_write(7'h00, 8'hFF, 1'b0);
    if (wr_ready !== 1'b1) ready_low++;
    do_write(7'h02, 8'h0F, 1'b0);
    if (wr_ready !== 1'b1) ready_low++;
    do_write(7'h00, 8'hAA, 1'b0);
    if (wr_ready !== 1'b1) ready_low++;
    n_vec++;
    if (ready_low != 0 || en_out !== 8'h00) begin
      n_err++;
      $display("FAIL merge_pre: got ready_low=%0d en_out=%h want 0/00", ready_low, en_out);
    end
    pulse_period();
    n_vec++;
    if (wr_ready !== 1'b0 || commit !== 1'b1) begin
      n_err++;
      $display("FAIL merge_commit_cycle: got r=%b c=%b want 0/1", wr_ready, commit);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (commit === 1'b1) pulses++;
    end
    n_vec++;
    if (en_out !== 8'hAA || pwm_out !== 8'h0F || en_uio !== 8'h00 || duty !== 8'h40 ||
        pulses != 0 || wr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL merge_result: got en=%h pwm=%h uio=%h duty=%h extra=%0d r=%b want aa/0f/00/40/0/1",
               en_out, pwm_out, en_uio, duty, pulses, wr_ready);
    end
  endtask

  task automatic test_simultaneous();
    do_write(7'h01, 8'h11, 1'b0);
    do_write(7'h01, 8'h33, 1'b1);
    n_vec++;
    if (commit !== 1'b1) begin
      n_err++;
      $display("FAIL simul_pending_commit: got c=%b want 1", commit);
    end
    tick();
    n_vec++;
    if (en_uio !== 8'h33 || pending !== 1'b0) begin
      n_err++;
      $display("FAIL simul_pending_data: got en_uio=%h p=%b want 33/0", en_uio, pending);
    end
    // In IDLE the write is taken but that period_start does not commit
    do_write(7'h03, 8'h55, 1'b1);
    n_vec++;
    if (commit !== 1'b0 || pending !== 1'b1) begin
      n_err++;
      $display("FAIL simul_idle_no_commit: got c=%b p=%b want 0/1", commit, pending);
    end
    tick();
    tick();
    n_vec++;
    if (pwm_uio !== 8'h00 || commit !== 1'b0) begin
      n_err++;
      $display("FAIL simul_idle_wait: got pwm_uio=%h c=%b want 00/0", pwm_uio, commit);
    end
    pulse_period();
    tick();
    n_vec++;
    if (pwm_uio !== 8'h55 || pending !== 1'b0) begin
      n_err++;
      $display("FAIL simul_idle_later: got pwm_uio=%h p=%b want 55/0", pwm_uio, pending);
    end
  endtask

  task automatic test_bad_addr();
    logic [6:0] bad_addr [2];
    bad_addr[0] = 7'h05;
    bad_addr[1] = 7'h7F;
    for (int k = 0; k < 2; k++) begin
      do_write(bad_addr[k], 8'h12, 1'b0);
      n_vec++;
      if (addr_err !== 1'b1 || pending !== 1'b0 || commit !== 1'b0) begin
        n_err++;
        $display("FAIL bad_addr_pulse[%h]: got e=%b p=%b c=%b want 1/0/0",
                 bad_addr[k], addr_err, pending, commit);
      end
      pulse_period();
      n_vec++;
      if (addr_err !== 1'b0 || commit !== 1'b0 || pending !== 1'b0 ||
          {en_out, en_uio, pwm_out, pwm_uio, duty} !== 40'hAA_33_0F_55_40) begin
        n_err++;
        $display("FAIL bad_addr_after[%h]: got e=%b c=%b p=%b regs=%h want 0/0/0/aa330f5540",
                 bad_addr[k], addr_err, commit, pending,
                 {en_out, en_uio, pwm_out, pwm_uio, duty});
      end
    end
  endtask

`ifdef PWM_CFG_TIMEOUT_EN
  task automatic test_timeout();
    int seen = 0;
    apply_reset();
    do_write(7'h04, 8'h10, 1'b0);
    for (int k = 1; k <= 40 && seen == 0; k++) begin
      tick();
      if (commit === 1'b1) seen = k;
    end
    n_vec++;
    if (seen != 16) begin
      n_err++;
      $display("FAIL timeout_cycle: got commit after %0d cycles want 16", seen);
    end
    tick();
    n_vec++;
    if (duty !== 8'h10 || pending !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_data: got duty=%h p=%b want 10/0", duty, pending);
    end
  endtask
`else
  task automatic test_no_timeout();
    int commits = 0;
    apply_reset();
    do_write(7'h04, 8'h10, 1'b0);
    for (int k = 0; k < 100; k++) begin
      tick();
      if (commit === 1'b1) commits++;
    end
    n_vec++;
    if (duty !== 8'h00 || pending !== 1'b1 || commits != 0) begin
      n_err++;
      $display("FAIL no_timeout: got duty=%h p=%b commits=%0d want 00/1/0",
               duty, pending, commits);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_commit();
    test_merge();
    test_simultaneous();
    test_bad_addr();
`ifdef PWM_CFG_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_cfg_scheduler.md
Name: pwm_cfg_scheduler

Overview:
- Sits between the SPI register-write decoder and the PWM/output stage of the UWASIC_Shiheng top level.
- Absorbs config writes into shadow registers.
- Commits all shadow registers to the active registers atomically, only at a PWM period boundary, so outputs never see a half-applied configuration or a mid-period duty change.
- Also flags dropped writes to unmapped addresses.

Parameters:
- NUM_REGS, 5, number of mapped config registers (addresses 0..NUM_REGS-1).
- TIMEOUT_CYCLES, 1024, forced-commit limit in clk cycles; used only with the optional feature.
- TO_W, 10, width of the timeout counter; must satisfy 2^TO_W >= TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- wr_valid  input  1  write request from SPI decoder
- wr_ready  output  1  scheduler can accept a write this cycle
- wr_addr  input  7  register address
- wr_data  input  8  register data
- period_start  input  1  one-cycle pulse from PWM counter at period wrap
- en_out  output  8  active reg 0x00, uo_out enable
- en_uio  output  8  active reg 0x01, uio_out enable
- pwm_out  output  8  active reg 0x02, uo_out PWM mode select
- pwm_uio  output  8  active reg 0x03, uio_out PWM mode select
- duty  output  8  active reg 0x04, PWM duty cycle
- pending  output  1  shadow differs from active (uncommitted write exists)
- commit  output  1  one-cycle pulse in the cycle the active regs load
- addr_err  output  1  one-cycle pulse when an accepted write hits an unmapped address

Behaviour:
- Reset (async, rst_n=0): all shadow and active regs = 0x00; state IDLE; pending=0, commit=0, addr_err=0; wr_ready=0 while rst_n=0. After release, wr_ready=1 from the first clock edge.
- Handshake: a write is accepted on a rising edge with wr_valid=1 and wr_ready=1. Data is not held across cycles.
- Address handling:
  - addr < NUM_REGS: the shadow reg is updated at that edge.
  - addr >= NUM_REGS: write is accepted and dropped; addr_err=1 for the next cycle; state is not changed.
- FSM states:
  - IDLE: wr_ready=1. A valid mapped write goes to PENDING. period_start is ignored.
  - PENDING: wr_ready=1. Further writes merge into the shadow; the last write to the same address wins. period_start=1 goes to COMMIT.
  - COMMIT: lasts exactly one cycle. wr_ready=0 and commit=1. At the closing edge, all NUM_REGS shadow regs copy to active; next state is IDLE.
- A mapped write accepted in the same cycle as period_start (in PENDING) is included in that commit.
- Latency: period_start sampled at edge N; active outputs change at edge N+1, the same edge that ends the commit pulse.
- Write and period_start in IDLE in the same cycle: the write is taken and the state moves to PENDING. The commit waits for the next period_start.
- pending = 1 in PENDING and COMMIT, else 0.
- Rewriting the current active value still counts as a write: it enters PENDING and produces a commit pulse.
- Reset mid-operation: uncommitted shadow contents are discarded; active regs go to 0x00 immediately (asynchronously).
- The active outputs are registered; none is driven combinationally from inputs.

Optional Feature:
- Macro: PWM_CFG_TIMEOUT_EN.
- Enabled:
  - A TO_W-bit counter clears on entry to PENDING and increments each cycle in PENDING.
  - When it reaches TIMEOUT_CYCLES-1 with no period_start, the FSM moves to COMMIT anyway.
  - This covers a stalled or disabled PWM counter. period_start in the same cycle has the same effect.
- Disabled: the counter logic is absent, and PENDING waits indefinitely for period_start.

Test Plan:
- Reset: assert rst_n=0 mid-run with duty=0x80 active -> all five outputs 0x00, pending=0, commit=0, wr_ready=0; after release, wr_ready=1.
- Basic commit: write addr 0x04 data 0x40, no period_start for 20 cycles -> duty stays 0x00 and pending=1. Pulse period_start -> commit pulses for one cycle; duty=0x40 one edge after the pulse; pending=0.
- Merge: write 0x00=0xFF, then 0x02=0x0F, then 0x00=0xAA, then period_start -> en_out=0xAA, pwm_out=0x0F committed in a single commit pulse. wr_ready=0 only during the COMMIT cycle.
- Simultaneous: in PENDING, write 0x01=0x33 in the same cycle as period_start -> en_uio=0x33 in that commit. In IDLE, write 0x03=0x55 with period_start -> no commit yet; pwm_uio=0x55 after the next period_start.
- Bad address: write addr 0x05 data 0x12 -> addr_err pulse; state stays IDLE; no active reg or pending change. Also write addr 0x7F.
- With PWM_CFG_TIMEOUT_EN and TIMEOUT_CYCLES=16: write 0x04=0x10 with no period_start -> commit exactly 16 cycles after entering PENDING and duty=0x10. Without the macro -> duty remains 0x00 after 100 cycles.
